fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_issue.sv | 104 ++++++++++
 tb/tb_fpu_issue.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fpu_issue.sv
// Issue/writeback sequencer for a multi-cycle FPU datapath: holds one operation
// in flight, counts its latency, captures the result and hands it to the core.
module fpu_issue #(
  parameter int LAT_FADD  = 1,
  parameter int LAT_FMUL  = 1,
  parameter int LAT_FDIV  = 4,
  parameter int LAT_FSQRT = 4,
  parameter int LAT_CVT   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  input  logic        flush,
  output logic [3:0]  fpu_control,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  input  logic [31:0] fpu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] lat;
  logic       accept;

  always_comb begin
    lat = 3'd0;
    case (req_op)
      4'd0, 4'd1:        lat = 3'(LAT_FADD);
      4'd2:              lat = 3'(LAT_FMUL);
      4'd3:              lat = 3'(LAT_FDIV);
      4'd6:              lat = 3'(LAT_FSQRT);
      4'd8, 4'd9, 4'd10: lat = 3'(LAT_CVT);
      default:           lat = 3'd0;
    endcase
  end

  assign req_ready = !flush && ((state == IDLE) || (state == DONE && wb_ready));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      fpu_control <= 4'd0;
      srcA        <= 32'd0;
      srcB        <= 32'd0;
      wb_data     <= 32'd0;
      wb_rd       <= 5'd0;
      wb_valid    <= 1'b0;
      busy        <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      wb_valid <= 1'b0;
      busy     <= 1'b0;
    end else if (accept) begin
      // Accept can happen in IDLE or straight out of DONE (back-to-back issue).
      state       <= EXEC;
      cnt         <= lat;
      fpu_control <= req_op;
      srcA        <= req_a;
      srcB        <= req_b;
      wb_rd       <= req_rd;
      wb_valid    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        EXEC: begin
          if (cnt == 3'd0) begin
            // Unassigned opcodes 11-15 complete with a zero result.
            wb_data  <= (fpu_control > 4'd10) ? 32'd0 : fpu_result;
            state    <= DONE;
            wb_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          if (wb_ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Randomized scoreboard bench for fpu_issue: a time-based reference predicts
// each writeback (data, tag, cycle it appears) and a monitor checks the DUT.
module tb_fpu_issue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        flush;
  logic [3:0]  fpu_control;
  logic [31:0] srcA, srcB;
  logic [31:0] fpu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        busy;

  always #5 clk = ~clk;

  fpu_issue dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_ready(req_ready),
    .flush(flush), .fpu_control(fpu_control), .srcA(srcA), .srcB(srcB),
    .fpu_result(fpu_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .busy(busy)
  );

  // Stand-in datapath: an arbitrary but operand- and opcode-dependent value.
  function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + {op, 28'h5a5a5a5};
  endfunction

  function automatic int op_lat(input logic [3:0] op);
    if (op <= 1) return 1;
    if (op == 2) return 1;
    if (op == 3) return 4;
    if (op == 6) return 4;
    if (op >= 8 && op <= 10) return 1;
    return 0;
  endfunction

  assign fpu_result = fpu_fn(fpu_control, srcA, srcB);

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;
  bit          rst_edge = 0;
  bit          accept_next = 0;
  logic [3:0]  cur_ctl = 4'd0;
  logic [31:0] cur_a = 32'd0, cur_b = 32'd0;

  // Reference model update at each edge; pushes predicted writebacks.
  always @(posedge clk) begin
    cycle    = cycle + 1;
    rst_edge = !rstn;
    if (!rstn) begin
      exp_q.delete();
      cur_ctl = 4'd0; cur_a = 32'd0; cur_b = 32'd0;
    end else if (flush) begin
      exp_q.delete();
    end else if (accept_next) begin
      exp_t e;
      e.data = (req_op > 4'd10) ? 32'd0 : fpu_fn(req_op, req_a, req_b);
      e.rd   = req_rd;
      e.due  = cycle + op_lat(req_op) + 1;
      exp_q.push_back(e);
      cur_ctl = req_op; cur_a = req_a; cur_b = req_b;
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    bit exp_valid, exp_ready;
    if (rst_edge) begin
      checks++;
      if ({fpu_control, srcA, srcB, wb_data, wb_rd, wb_valid, busy} != '0) begin
        failures++;
        $display("FAIL reset_vals cyc=%0d ctl=%h a=%h b=%h d=%h rd=%0d v=%b busy=%b req=all zero",
                 cycle, fpu_control, srcA, srcB, wb_data, wb_rd, wb_valid, busy);
      end
    end
    exp_valid = (exp_q.size() > 0) && (cycle >= exp_q[0].due);
    checks++;
    if (wb_valid !== exp_valid || busy !== (exp_q.size() > 0)) begin
      failures++;
      $display("FAIL valid_busy cyc=%0d wb_valid=%b busy=%b req wb_valid=%b busy=%b",
               cycle, wb_valid, busy, exp_valid, exp_q.size() > 0);
    end
    checks++;
    if ({fpu_control, srcA, srcB} !== {cur_ctl, cur_a, cur_b}) begin
      failures++;
      $display("FAIL operands cyc=%0d got %h/%h/%h req %h/%h/%h",
               cycle, fpu_control, srcA, srcB, cur_ctl, cur_a, cur_b);
    end
    if (wb_valid && exp_q.size() > 0) begin
      checks++;
      if (wb_data !== exp_q[0].data || wb_rd !== exp_q[0].rd) begin
        failures++;
        $display("FAIL wb_result cyc=%0d got data=%h rd=%0d req data=%h rd=%0d",
                 cycle, wb_data, wb_rd, exp_q[0].data, exp_q[0].rd);
      end else begin
        $display("wb cyc=%0d data=%h rd=%0d ready=%b", cycle, wb_data, wb_rd, wb_ready);
      end
    end
    accept_next = 0;
    if (rstn) begin
      exp_ready = !flush && ((exp_q.size() == 0) || (exp_valid && wb_ready));
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL req_ready cyc=%0d got %b req %b", cycle, req_ready, exp_ready);
      end
      accept_next = req_valid && exp_ready;
      if (accept_next)
        $display("issue cyc=%0d op=%0d a=%h b=%h rd=%0d", cycle, req_op, req_a, req_b, req_rd);
      if (!flush && exp_valid && wb_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    req_rd = 5'd0; flush = 1'b0; wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      req_valid = ($urandom % 3) != 0;
      req_op    = 4'($urandom % 16);
      req_a     = $urandom;
      req_b     = $urandom;
      req_rd    = 5'($urandom % 32);
      wb_ready  = ($urandom % 4) != 0;
      flush     = ($urandom % 40) == 0;
      rstn      = ($urandom % 150) != 0;
    end
    @(posedge clk);
    #2 req_valid = 1'b0; flush = 1'b0; rstn = 1'b1; wb_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
